// File: rtl/bj_timer_pkg.sv
// Shared constants for the blackjack timer blocks.
// Provides the timer FSM state encoding and the default turn limits used by the
// game controller when it instantiates turn_timer.
package bj_timer_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_EXP   = 2'd3;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StRun   = S_RUN,
    StPause = S_PAUSE,
    StExp   = S_EXP
  } timer_state_e;

  localparam int unsigned TURN_LIMIT_DEF = 15;
  localparam int unsigned WARN_AT_DEF    = 5;
  localparam int unsigned CW_DEF         = 8;

endpackage

// File: rtl/turn_timer_if.sv
// Bundle between the game controller and the turn timer.
//   time_ms   : timebase count (controller -> timer)
//   start     : 1-cycle load/restart command
//   stop      : 1-cycle abandon command
//   pause     : level, hold the count
//   remaining : time left
//   running   : RUNNING or PAUSED
//   warn      : low-time warning
//   timeout   : 1-cycle pulse when the count reaches 0
//   expired   : level, countdown finished
interface turn_timer_if #(
  parameter int unsigned CW = 8
);
  logic [31:0]   time_ms;
  logic          start;
  logic          stop;
  logic          pause;
  logic [CW-1:0] remaining;
  logic          running;
  logic          warn;
  logic          timeout;
  logic          expired;

  modport master (
    output time_ms, start, stop, pause,
    input  remaining, running, warn, timeout, expired
  );

  modport slave (
    input  time_ms, start, stop, pause,
    output remaining, running, warn, timeout, expired
  );
endinterface

// File: rtl/tick_detect.sv
// Turns a free-running timebase count into a tick strobe.
// Any change of value (including a decrease on wrap or timebase reset) is one tick.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   value : timebase count
//   tick  : high in any cycle where value differs from last cycle's value
module tick_detect (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  output logic        tick
);

  logic [31:0] prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= value;
    end
  end

  assign tick = (value != prev_q);

endmodule

// File: rtl/turn_timer.sv
// Player-turn countdown. Counts TURN_LIMIT timebase ticks down to zero, with
// pause/stop/restart control, a low-time warning and a timeout pulse.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : turn_timer_if slave (time_ms/start/stop/pause in; status out)
module turn_timer
  import bj_timer_pkg::*;
#(
  parameter int unsigned TURN_LIMIT = TURN_LIMIT_DEF,
  parameter int unsigned WARN_AT    = WARN_AT_DEF,
  parameter int unsigned CW         = CW_DEF
) (
  input  logic         clk,
  input  logic         rst,
  turn_timer_if.slave  bus
);

  if (TURN_LIMIT < 1 || TURN_LIMIT > (2 ** CW) - 1 || WARN_AT >= TURN_LIMIT)
  begin : g_param_err
    $error("turn_timer: TURN_LIMIT/WARN_AT out of range for CW");
  end

  localparam logic [CW-1:0] Limit = CW'(TURN_LIMIT);
  localparam logic [CW-1:0] WarnAt = CW'(WARN_AT);

  logic tick;

  tick_detect u_tick_detect (
    .clk   (clk),
    .rst   (rst),
    .value (bus.time_ms),
    .tick  (tick)
  );

  timer_state_e  state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          warn_q, warn_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    timeout_d = 1'b0;

    // stop > start > pause > tick
    if (bus.stop) begin
      state_d = StIdle;
      rem_d   = '0;
    end else if (bus.start) begin
      state_d = StRun;
      rem_d   = Limit;
    end else begin
      unique case (state_q)
        StRun: begin
          if (bus.pause) begin
            state_d = StPause;
          end else if (tick) begin
            if (rem_q > CW'(1)) begin
              rem_d = rem_q - CW'(1);
            end else begin
              // Last tick: saturate at 0 and fire the timeout strobe once.
              rem_d     = '0;
              state_d   = StExp;
              timeout_d = 1'b1;
            end
          end
        end
        StPause: begin
          // Ticks seen while paused are dropped, not queued.
          if (!bus.pause) begin
            state_d = StRun;
          end
        end
        StExp:   rem_d = '0;
        default: rem_d = '0;
      endcase
    end

    warn_d = ((state_d == StRun) || (state_d == StPause)) &&
             (rem_d != '0) && (rem_d <= WarnAt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      warn_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      warn_q    <= warn_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.remaining = rem_q;
  assign bus.warn      = warn_q;
  assign bus.timeout   = timeout_q;
  assign bus.running   = (state_q == StRun) || (state_q == StPause);
  assign bus.expired   = (state_q == StExp);

endmodule

// File: tb/tb_turn_timer.sv
// Bench for turn_timer: directed scenarios followed by random commands and
// timebase changes, all checked against a behavioural countdown model.
module tb_turn_timer;

  localparam int Limit = 15;
  localparam int Warn  = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  turn_timer_if #(.CW(8)) bus ();

  turn_timer #(
    .TURN_LIMIT (Limit),
    .WARN_AT    (Warn),
    .CW         (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: countdown value plus three flags.
  bit          m_active;
  bit          m_paused;
  bit          m_done;
  bit          m_timeout;
  int          m_rem;
  logic [31:0] m_prev;
  logic [31:0] cur_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_paused  = 0;
    m_done    = 0;
    m_timeout = 0;
    m_rem     = 0;
    m_prev    = '0;
  endtask

  task automatic model_step(input logic [31:0] t, input bit st, input bit sp, input bit pa);
    bit tk;
    tk        = (t != m_prev);
    m_prev    = t;
    m_timeout = 0;
    if (sp) begin
      m_active = 0; m_paused = 0; m_done = 0; m_rem = 0;
    end else if (st) begin
      m_active = 1; m_paused = 0; m_done = 0; m_rem = Limit;
    end else if (m_active && !m_paused) begin
      if (pa) begin
        m_paused = 1;
      end else if (tk) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_active  = 0;
          m_done    = 1;
          m_timeout = 1;
        end
      end
    end else if (m_active && m_paused && !pa) begin
      m_paused = 0;
    end
  endtask

  task automatic check_model(input string tag);
    bit w;
    w = m_active && (m_rem > 0) && (m_rem <= Warn);
    check({tag, "_rem"}, 32'(bus.remaining), 32'(m_rem));
    check({tag, "_running"}, 32'(bus.running), 32'(m_active));
    check({tag, "_warn"}, 32'(bus.warn), 32'(w));
    check({tag, "_timeout"}, 32'(bus.timeout), 32'(m_timeout));
    check({tag, "_expired"}, 32'(bus.expired), 32'(m_done));
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1 ns later.
  task automatic step(input string tag, input logic [31:0] t,
                      input bit st, input bit sp, input bit pa);
    @(negedge clk);
    bus.time_ms = t;
    bus.start   = st;
    bus.stop    = sp;
    bus.pause   = pa;
    cur_t       = t;
    @(posedge clk);
    model_step(t, st, sp, pa);
    #1;
    check_model(tag);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic tick(input string tag, input bit pa);
    step(tag, cur_t + 32'd1, 1'b0, 1'b0, pa);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rem"}, 32'(bus.remaining), 32'd0);
    check({tag, "_running"}, 32'(bus.running), 32'd0);
    check({tag, "_warn"}, 32'(bus.warn), 32'd0);
    check({tag, "_timeout"}, 32'(bus.timeout), 32'd0);
    check({tag, "_expired"}, 32'(bus.expired), 32'd0);
  endtask

  initial begin
    bit pa_lvl;
    int r;
    logic [31:0] nt;

    bus.time_ms = '0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    cur_t       = '0;
    model_reset();

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    @(negedge clk);
    rst = 1'b1;

    // Full run to expiry.
    step("full_start", cur_t, 1'b1, 1'b0, 1'b0);
    check("full_start_15", 32'(bus.remaining), 32'd15);
    for (int i = 0; i < 14; i++) tick("full_tick", 1'b0);
    check("full_rem1", 32'(bus.remaining), 32'd1);
    check("full_warn1", 32'(bus.warn), 32'd1);
    tick("full_last", 1'b0);
    check("full_timeout", 32'(bus.timeout), 32'd1);
    check("full_expired", 32'(bus.expired), 32'd1);
    check("full_running", 32'(bus.running), 32'd0);
    for (int i = 0; i < 3; i++) tick("full_extra", 1'b0);
    check("full_extra_rem", 32'(bus.remaining), 32'd0);
    check("full_extra_timeout", 32'(bus.timeout), 32'd0);

    // Restart from expired.
    step("restart", cur_t, 1'b1, 1'b0, 1'b0);
    check("restart_rem", 32'(bus.remaining), 32'd15);
    check("restart_expired", 32'(bus.expired), 32'd0);
    check("restart_running", 32'(bus.running), 32'd1);
    check("restart_timeout", 32'(bus.timeout), 32'd0);

    // Pause holds the count and drops ticks.
    for (int i = 0; i < 3; i++) tick("pause_pre", 1'b0);
    check("pause_pre12", 32'(bus.remaining), 32'd12);
    step("pause_enter", cur_t, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick("pause_hold", 1'b1);
    check("pause_held12", 32'(bus.remaining), 32'd12);
    step("pause_release", cur_t, 1'b0, 1'b0, 1'b0);
    tick("pause_post", 1'b0);
    check("pause_post11", 32'(bus.remaining), 32'd11);

    // Collisions.
    step("col_start_tick", cur_t + 32'd1, 1'b1, 1'b0, 1'b0);
    check("col_start_tick15", 32'(bus.remaining), 32'd15);
    step("col_stop_start", cur_t, 1'b1, 1'b1, 1'b0);
    check("col_stop_start_rem", 32'(bus.remaining), 32'd0);
    check("col_stop_start_run", 32'(bus.running), 32'd0);
    step("col_restart", cur_t, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick("col_pre", 1'b0);
    tick("col_pause_tick", 1'b1);
    check("col_pause_tick12", 32'(bus.remaining), 32'd12);
    step("col_unpause", cur_t, 1'b0, 1'b0, 1'b0);

    // Timebase wrap counts as a single tick.
    step("wrap_idle", 32'hFFFF_FFF9, 1'b0, 1'b1, 1'b0);
    step("wrap_start", cur_t, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick("wrap_pre", 1'b0);
    check("wrap_at9", 32'(bus.remaining), 32'd9);
    step("wrap", 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    check("wrap_to8", 32'(bus.remaining), 32'd8);

    // Async reset mid-countdown at remaining=7.
    tick("rst_pre", 1'b0);
    check("rst_pre7", 32'(bus.remaining), 32'd7);
    @(posedge clk);
    #5;
    rst = 1'b0;
    #1;
    check_all_zero("rst_async");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick("rst_idle_tick", 1'b0);
    check("rst_idle_rem", 32'(bus.remaining), 32'd0);

    // Random commands and timebase activity.
    pa_lvl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 45) nt = cur_t + 32'd1;
      else if (r < 55) nt = $urandom;
      else nt = cur_t;
      if ($urandom_range(0, 99) < 12) pa_lvl = ~pa_lvl;
      step("rand", nt, ($urandom_range(0, 99) < 6), ($urandom_range(0, 99) < 2), pa_lvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
